// File: rtl/or_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
package or_rr_arbiter_pkg;

   // FSM state encodings
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   // Ceiling log2, used to size counters and to validate the grant index width
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/or_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate, fixed-priority encode, un-rotate.
module or_rr_arbiter_rr_pick #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] last_i,
   output logic           any_o,
   output logic [IDW-1:0] pick_id_o,
   output logic [N-1:0]   pick_oh_o
);

   logic [N-1:0] rot;
   int unsigned  j_sel;
   int unsigned  idx;

   // Rotate so the requester just after 'last' sits at bit 0, take the lowest set bit, map back
   always_comb begin
      rot   = '0;
      j_sel = 0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req_i[IDW'((i + int'(last_i) + 1) % N)];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) j_sel = i;
      end
      idx       = (j_sel + int'(last_i) + 1) % N;
      any_o     = |req_i;
      pick_id_o = IDW'(idx);
      pick_oh_o = '0;
      if (any_o) pick_oh_o[IDW'(idx)] = 1'b1;
   end

endmodule

// File: rtl/or_rr_arbiter.sv
// Round-robin arbiter: one owner at a time, hold-timeout release, one idle cycle between grants.
module or_rr_arbiter
   import or_rr_arbiter_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned IDW      = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           timeout
);

   localparam int unsigned HCW         = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
   localparam int unsigned HOLD_LAST   = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [HCW-1:0] HOLD_LAST_C = HCW'(HOLD_LAST);
   localparam logic        LIMITED     = (MAX_HOLD != 0);

   // Reject a grant index width that does not match the requester count
   if (IDW != clog2(N)) begin : g_bad_idw
      $error("or_rr_arbiter: IDW must equal clog2(N)");
   end

   logic           state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           timeout_q, timeout_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
   logic [IDW-1:0] last_q, last_d;

   logic           any;
   logic [IDW-1:0] pick_id;
   logic [N-1:0]   pick_oh;
   logic           owner_req;
   logic           hold_hit;

   or_rr_arbiter_rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req_i     (req),
      .last_i    (last_q),
      .any_o     (any),
      .pick_id_o (pick_id),
      .pick_oh_o (pick_oh)
   );

   // Next-state and output decode for the IDLE/GRANT machine
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_d      = last_q;
      owner_req   = req[gnt_id_q];
      hold_hit    = LIMITED && (hold_cnt_q == HOLD_LAST_C);

      if (state_q == ST_IDLE) begin
         if (any) begin
            gnt_d       = pick_oh;
            gnt_valid_d = 1'b1;
            gnt_id_d    = pick_id;
            hold_cnt_d  = '0;
            state_d     = ST_GRANT;
         end
      end else begin
         if (!owner_req || hold_hit) begin
            // Timeout is flagged only when the owner still wanted the resource
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            last_d      = gnt_id_q;
            timeout_d   = owner_req;
            state_d     = ST_IDLE;
         end else if (hold_cnt_q != HOLD_LAST_C) begin
            hold_cnt_d  = hold_cnt_q + HCW'(1);
         end
      end
   end

   // State and output registers; reset gives requester 0 first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         last_q      <= IDW'(N - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         last_q      <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;

   // Requests must never carry X/Z while out of reset
   req_known_a: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));

endmodule

// File: tb/tb_or_rr_arbiter.sv
// Scoreboard bench for or_rr_arbiter: limited-hold instance plus an unlimited-hold instance.
module tb_or_rr_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic       v;
      logic [1:0] id;
      logic       to;
   } exp_t;

   localparam exp_t RST = '{gnt: 4'b0000, v: 1'b0, id: 2'd0, to: 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_a = 4'b1111, req_b = 4'b1111;
   logic [3:0] gnt_a, gnt_b;
   logic       v_a, v_b, to_a, to_b;
   logic [1:0] id_a, id_b;

   int checks = 0;
   int failures = 0;

   exp_t sb_a[$];
   exp_t sb_b[$];

   // Reference model state, index 0 = limited instance, 1 = unlimited instance
   int owner[2];
   int held[2];
   int last_m[2];
   int id_m[2];
   int to_m[2];

   or_rr_arbiter #(.N(4), .MAX_HOLD(8), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req_a),
      .gnt(gnt_a), .gnt_valid(v_a), .gnt_id(id_a), .timeout(to_a)
   );

   or_rr_arbiter #(.N(4), .MAX_HOLD(0), .IDW(2)) dut_nh (
      .clk(clk), .rst_n(rst_n), .req(req_b),
      .gnt(gnt_b), .gnt_valid(v_b), .gnt_id(id_b), .timeout(to_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void mreset(int m);
      owner[m]  = -1;
      held[m]   = 0;
      last_m[m] = 3;
      id_m[m]   = 0;
      to_m[m]   = 0;
   endfunction

   // One clock of arbitration rules: round-robin pick, owner hold, forced release
   function automatic exp_t step(int m, logic [3:0] r, int mh);
      exp_t e;
      if (owner[m] < 0) begin
         to_m[m] = 0;
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last_m[m] + k) % 4;
            if (r[c] && owner[m] < 0) begin
               owner[m] = c;
               held[m]  = 1;
               id_m[m]  = c;
            end
         end
      end else if (!r[owner[m]]) begin
         to_m[m]   = 0;
         last_m[m] = owner[m];
         owner[m]  = -1;
      end else if (mh != 0 && held[m] == mh) begin
         to_m[m]   = 1;
         last_m[m] = owner[m];
         owner[m]  = -1;
      end else begin
         held[m]++;
         to_m[m] = 0;
      end
      e.gnt = (owner[m] >= 0) ? 4'(1 << owner[m]) : 4'b0000;
      e.v   = (owner[m] >= 0);
      e.id  = 2'(id_m[m]);
      e.to  = (to_m[m] != 0);
      return e;
   endfunction

   // Model advances on the same edge as the DUT and queues the expected outputs
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mreset(0);
         mreset(1);
         sb_a.delete();
         sb_b.delete();
      end else begin
         sb_a.push_back(step(0, req_a, 8));
         sb_b.push_back(step(1, req_b, 0));
      end
   end

   // Monitor: compare presented outputs against queued expectations
   always @(negedge clk) begin
      exp_t ea, eb;
      ea = RST;
      eb = RST;
      if (rst_n) begin
         if (sb_a.size() > 0) ea = sb_a.pop_front();
         if (sb_b.size() > 0) eb = sb_b.pop_front();
      end
      chk(rst_n ? "sb_limited" : "reset_limited", 32'({gnt_a, v_a, id_a, to_a}), 32'(ea));
      chk(rst_n ? "sb_unlimited" : "reset_unlimited", 32'({gnt_b, v_b, id_b, to_b}), 32'(eb));
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (v_a) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s: no grant within 10 cycles, got gnt=%b", nm, gnt_a);
      end
   endtask

   initial begin
      int order[$];
      int expo[5];
      int n_to;
      bit prev;
      expo = '{0, 1, 2, 3, 0};

      // Reset held with all requests up
      repeat (4) @(posedge clk);
      #1;
      chk("reset_gnt", 32'(gnt_a), 32'd0);
      rst_n = 1'b1;
      req_b = 4'b0010;

      // All requesters asserted: service order and timeout pulses
      req_a = 4'b1111;
      prev = 1'b0;
      n_to = 0;
      for (int i = 0; i < 45; i++) begin
         cyc(1);
         if (v_a && !prev) order.push_back(int'(id_a));
         if (to_a) n_to++;
         prev = v_a;
      end
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("order_%0d", i), (order.size() > i) ? 32'(order[i]) : 32'hffff_ffff, 32'(expo[i]));
      end
      chk("timeout_count", 32'(n_to), 32'd5);
      req_a = 4'b0000;
      cyc(3);

      // Single requester: one-cycle latency, normal release
      req_a = 4'b0001;
      cyc(1);
      chk("single_gnt", 32'(gnt_a), 32'b0001);
      cyc(2);
      req_a = 4'b0000;
      cyc(1);
      chk("single_release", 32'({gnt_a, to_a}), 32'd0);
      cyc(2);

      // Wrap: after serving 3, requester 0 beats requester 3
      req_a = 4'b1000;
      wait_gnt("wrap_first");
      @(posedge clk); #1;
      req_a = 4'b0000;
      cyc(3);
      req_a = 4'b1001;
      wait_gnt("wrap_second");
      chk("wrap_gnt", 32'(gnt_a), 32'b0001);
      @(posedge clk); #1;
      req_a = 4'b0000;
      cyc(3);

      // Owner drops on the final allowed cycle: release without timeout
      req_a = 4'b0010;
      wait_gnt("simul_gnt");
      @(posedge clk); #1;
      cyc(6);
      req_a = 4'b0000;
      cyc(1);
      chk("simul_gnt_drop", 32'(gnt_a), 32'd0);
      chk("simul_timeout", 32'(to_a), 32'd0);
      cyc(2);

      // Randomized request traffic with sticky requests
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) req_a = 4'($urandom);
         cyc(1);
      end
      req_a = 4'b0000;
      cyc(3);

      // Asynchronous reset in the middle of a grant
      req_a = 4'b0100;
      wait_gnt("async_gnt");
      chk("async_pre", 32'(gnt_a), 32'b0100);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gnt_clear", 32'({gnt_a, v_a, to_a}), 32'd0);
      chk("async_unlim_clear", 32'({gnt_b, v_b}), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      req_a = 4'b0101;
      wait_gnt("prio_restore_gnt");
      chk("prio_restore", 32'(gnt_a), 32'b0001);

      req_a = 4'b0000;
      req_b = 4'b0000;
      cyc(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
